// File: rtl/arbiter_pkg.sv
// Shared types and response codes for the Avalon-MM round-robin arbiter.
package arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/rr_onehot_picker.sv
// Round-robin one-hot picker: first set bit of req at or after rr_ptr, cyclically.
module rr_onehot_picker #(
  parameter int unsigned N     = 2,
  parameter int unsigned PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] rr_ptr,
  output logic [N-1:0]     pick
);

  localparam int unsigned W2 = 2 * N;

  logic [W2-1:0] dbl;
  logic [W2-1:0] mask;
  logic [W2-1:0] masked;
  logic [W2-1:0] lowest;

  // Upper copy of req catches the wrap-around once bits below rr_ptr are masked off.
  always_comb begin
    dbl    = {req, req};
    mask   = ~((W2'(1) << rr_ptr) - W2'(1));
    masked = dbl & mask;
    lowest = masked & (~masked + W2'(1));
    pick   = lowest[N-1:0] | lowest[W2-1:N];
  end

endmodule

// File: rtl/avalon_mm_rr_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM control slave between NUM_MASTERS requesters,
// one transaction at a time, with a watchdog that completes stuck transfers with SLVERR.
module avalon_mm_rr_arbiter
  import arbiter_pkg::*;
#(
  parameter int unsigned NUM_MASTERS    = 2,
  parameter int unsigned ADDR_WIDTH     = 4,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]   m_address,
  input  logic [NUM_MASTERS-1:0]              m_read,
  input  logic [NUM_MASTERS-1:0]              m_write,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0]   m_writedata,
  input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0] m_byteenable,
  output logic [DATA_WIDTH-1:0]               m_readdata,
  output logic [1:0]                          m_response,
  output logic [NUM_MASTERS-1:0]              m_waitrequest,
  output logic [ADDR_WIDTH-1:0]               s_address,
  output logic                                s_read,
  output logic                                s_write,
  output logic [DATA_WIDTH-1:0]               s_writedata,
  output logic [DATA_WIDTH/8-1:0]             s_byteenable,
  input  logic [DATA_WIDTH-1:0]               s_readdata,
  input  logic [1:0]                          s_response,
  input  logic                                s_waitrequest,
  output logic [NUM_MASTERS-1:0]              grant,
  output logic                                timeout_err
);

  localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned PTR_W    = $clog2(NUM_MASTERS);
  localparam int unsigned WD_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST =
    WD_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_MASTERS - 1);
  localparam bit WD_EN = (TIMEOUT_CYCLES > 0);

  state_e                 state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [PTR_W-1:0]       gidx_q, gidx_d;
  logic [PTR_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [WD_W-1:0]        wd_cnt_q, wd_cnt_d;

  logic [NUM_MASTERS-1:0] req;
  logic [NUM_MASTERS-1:0] pick;
  logic [PTR_W-1:0]       pick_idx;
  logic                   busy;
  logic                   g_read;
  logic                   g_write;
  logic                   g_req;
  logic                   wd_fire;
  logic                   done;

  assign req   = m_read | m_write;
  assign grant = grant_q;

  rr_onehot_picker #(
    .N     (NUM_MASTERS),
    .PTR_W (PTR_W)
  ) u_picker (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .pick   (pick)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (pick[i]) pick_idx = PTR_W'(i);
    end
  end

  // AND-OR mux of the granted master's payload; grant_q is zero while idle.
  always_comb begin
    s_address    = '0;
    s_writedata  = '0;
    s_byteenable = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      s_address    |= m_address[i*ADDR_WIDTH +: ADDR_WIDTH]     & {ADDR_WIDTH{grant_q[i]}};
      s_writedata  |= m_writedata[i*DATA_WIDTH +: DATA_WIDTH]   & {DATA_WIDTH{grant_q[i]}};
      s_byteenable |= m_byteenable[i*BE_WIDTH +: BE_WIDTH]      & {BE_WIDTH{grant_q[i]}};
    end
  end

  always_comb begin
    busy    = (state_q == BUSY);
    g_read  = |(m_read & grant_q);
    g_write = |(m_write & grant_q);
    g_req   = g_read | g_write;
    // A slave completion on the expiry cycle takes precedence over the watchdog.
    wd_fire = WD_EN && busy && g_req && s_waitrequest && (wd_cnt_q == WD_LAST);
    done    = busy && g_req && !s_waitrequest;
  end

  // Next state and transfer-phase outputs.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    gidx_d        = gidx_q;
    rr_ptr_d      = rr_ptr_q;
    wd_cnt_d      = wd_cnt_q;
    s_read        = 1'b0;
    s_write       = 1'b0;
    m_waitrequest = '1;
    m_readdata    = '0;
    m_response    = RESP_OKAY;
    timeout_err   = 1'b0;

    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d  = BUSY;
          grant_d  = pick;
          gidx_d   = pick_idx;
          wd_cnt_d = '0;
        end
      end
      BUSY: begin
        s_read        = g_read && !wd_fire;
        s_write       = g_write && !g_read && !wd_fire;
        m_waitrequest = ~grant_q | {NUM_MASTERS{s_waitrequest && !wd_fire}};
        timeout_err   = wd_fire;
        if (done) begin
          m_readdata = s_readdata;
          m_response = s_response;
        end else if (wd_fire) begin
          m_response = RESP_SLVERR;
        end
        if (done || wd_fire || !g_req) begin
          state_d  = IDLE;
          grant_d  = '0;
          rr_ptr_d = (gidx_q == PTR_LAST) ? '0 : gidx_q + PTR_W'(1);
        end else begin
          wd_cnt_d = wd_cnt_q + WD_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      gidx_q   <= '0;
      rr_ptr_q <= '0;
      wd_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      gidx_q   <= gidx_d;
      rr_ptr_q <= rr_ptr_d;
      wd_cnt_q <= wd_cnt_d;
    end
  end

endmodule

// File: tb/tb_avalon_mm_rr_arbiter.sv
// Bench for avalon_mm_rr_arbiter: cycle vector table, hand-written corner sequences,
// and a randomized run against a transaction-level reference model.
module tb_avalon_mm_rr_arbiter;

  localparam int unsigned N  = 2;
  localparam int unsigned AW = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = DW / 8;
  localparam int unsigned TO = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [N*AW-1:0] m_address;
  logic [N-1:0]    m_read, m_write;
  logic [N*DW-1:0] m_writedata;
  logic [N*BW-1:0] m_byteenable;
  logic [DW-1:0]   m_readdata;
  logic [1:0]      m_response;
  logic [N-1:0]    m_waitrequest;
  logic [AW-1:0]   s_address;
  logic            s_read, s_write;
  logic [DW-1:0]   s_writedata;
  logic [BW-1:0]   s_byteenable;
  logic [DW-1:0]   s_readdata;
  logic [1:0]      s_response;
  logic            s_waitrequest;
  logic [N-1:0]    grant;
  logic            timeout_err;

  logic [AW-1:0] maddr  [N];
  logic [DW-1:0] mwdata [N];
  logic [BW-1:0] mbe    [N];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      m_address[i*AW +: AW]    = maddr[i];
      m_writedata[i*DW +: DW]  = mwdata[i];
      m_byteenable[i*BW +: BW] = mbe[i];
    end
  end

  avalon_mm_rr_arbiter #(
    .NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .m_address(m_address), .m_read(m_read), .m_write(m_write),
    .m_writedata(m_writedata), .m_byteenable(m_byteenable),
    .m_readdata(m_readdata), .m_response(m_response), .m_waitrequest(m_waitrequest),
    .s_address(s_address), .s_read(s_read), .s_write(s_write),
    .s_writedata(s_writedata), .s_byteenable(s_byteenable),
    .s_readdata(s_readdata), .s_response(s_response), .s_waitrequest(s_waitrequest),
    .grant(grant), .timeout_err(timeout_err)
  );

  typedef struct packed {
    logic [N-1:0]  grant;
    logic          s_read;
    logic          s_write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [BW-1:0] be;
    logic [N-1:0]  mwr;
    logic [DW-1:0] rdata;
    logic [1:0]    resp;
    logic          to;
  } obs_t;

  typedef struct {
    logic [N-1:0]  rd;
    logic [N-1:0]  wr;
    logic          sw;
    logic [DW-1:0] srd;
    logic [1:0]    sresp;
    obs_t          exp;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   passed = 0;

  // Reference model state: a transaction owner, a rotating start index and elapsed wait.
  int m_busy, m_owner, m_ptr, m_elapsed;

  function automatic obs_t observe();
    obs_t o;
    o.grant = grant;     o.s_read = s_read;       o.s_write = s_write;
    o.addr  = s_address; o.wdata  = s_writedata;  o.be      = s_byteenable;
    o.mwr   = m_waitrequest; o.rdata = m_readdata; o.resp = m_response;
    o.to    = timeout_err;
    return o;
  endfunction

  function automatic obs_t idle_obs();
    obs_t o = '0;
    o.mwr = '1;
    return o;
  endfunction

  function automatic obs_t busy_obs(int o, logic sr, logic sw, logic [N-1:0] mwr,
                                    logic [DW-1:0] rdata, logic [1:0] resp, logic to);
    obs_t e;
    e.grant = N'(1) << o;
    e.s_read = sr; e.s_write = sw;
    e.addr = maddr[o]; e.wdata = mwdata[o]; e.be = mbe[o];
    e.mwr = mwr; e.rdata = rdata; e.resp = resp; e.to = to;
    return e;
  endfunction

  task automatic check(input string name, input obs_t act, input obs_t exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, required %h", name, act, exp);
  endtask

  task automatic add_row(input logic [N-1:0] rd, input logic [N-1:0] wr, input logic sw,
                         input logic [DW-1:0] srd, input logic [1:0] sresp, input obs_t exp);
    vec_t v;
    v.rd = rd; v.wr = wr; v.sw = sw; v.srd = srd; v.sresp = sresp; v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic cyc(input logic [N-1:0] rd, input logic [N-1:0] wr, input logic sw,
                     input logic [DW-1:0] srd, input logic [1:0] sresp);
    @(negedge clk);
    m_read = rd; m_write = wr; s_waitrequest = sw; s_readdata = srd; s_response = sresp;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m_read = '0; m_write = '0; s_waitrequest = 1'b0; s_readdata = '0; s_response = 2'b00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin
    obs_t e;
    maddr[0] = 4'h4; mwdata[0] = 32'hDEAD_BEEF; mbe[0] = 4'h3;
    maddr[1] = 4'h0; mwdata[1] = 32'h0000_0005; mbe[1] = 4'hF;

    // Cycle table from reset, rr pointer starting at m0.
    add_row(2'b01, 2'b00, 1'b1, 32'h0,        2'b00, idle_obs());
    add_row(2'b01, 2'b00, 1'b1, 32'h0,        2'b00, busy_obs(0, 1, 0, 2'b11, 0, 2'b00, 0));
    add_row(2'b01, 2'b00, 1'b1, 32'h0,        2'b00, busy_obs(0, 1, 0, 2'b11, 0, 2'b00, 0));
    add_row(2'b01, 2'b00, 1'b0, 32'h00FF_FFFF, 2'b00,
            busy_obs(0, 1, 0, 2'b10, 32'h00FF_FFFF, 2'b00, 0));
    add_row(2'b00, 2'b00, 1'b0, 32'h0,        2'b00, idle_obs());
    add_row(2'b11, 2'b00, 1'b0, 32'hA5,       2'b00, idle_obs());
    add_row(2'b11, 2'b00, 1'b0, 32'hA5,       2'b00, busy_obs(1, 1, 0, 2'b01, 32'hA5, 2'b00, 0));
    add_row(2'b11, 2'b00, 1'b0, 32'hA5,       2'b00, idle_obs());
    add_row(2'b11, 2'b00, 1'b0, 32'hA5,       2'b00, busy_obs(0, 1, 0, 2'b10, 32'hA5, 2'b00, 0));
    add_row(2'b11, 2'b00, 1'b0, 32'hA5,       2'b00, idle_obs());
    add_row(2'b11, 2'b00, 1'b0, 32'hA5,       2'b00, busy_obs(1, 1, 0, 2'b01, 32'hA5, 2'b00, 0));
    add_row(2'b00, 2'b10, 1'b0, 32'h0,        2'b00, idle_obs());
    add_row(2'b00, 2'b10, 1'b0, 32'h0,        2'b00, busy_obs(1, 0, 1, 2'b01, 0, 2'b00, 0));
    add_row(2'b01, 2'b00, 1'b0, 32'h77,       2'b10, idle_obs());
    add_row(2'b01, 2'b00, 1'b0, 32'h77,       2'b10, busy_obs(0, 1, 0, 2'b10, 32'h77, 2'b10, 0));
    add_row(2'b01, 2'b01, 1'b0, 32'h0,        2'b00, idle_obs());
    add_row(2'b01, 2'b01, 1'b0, 32'h0,        2'b00, busy_obs(0, 1, 0, 2'b10, 0, 2'b00, 0));
    add_row(2'b00, 2'b00, 1'b0, 32'h0,        2'b00, idle_obs());

    do_reset();
    #1;
    check("reset_state", observe(), idle_obs());

    for (int i = 0; i < vecs.size(); i++) begin
      cyc(vecs[i].rd, vecs[i].wr, vecs[i].sw, vecs[i].srd, vecs[i].sresp);
      check($sformatf("vec%0d", i), observe(), vecs[i].exp);
    end

    // Watchdog expiry on the 16th BUSY cycle with waitrequest stuck high.
    cyc(2'b01, 2'b00, 1'b1, 32'h1234, 2'b00);
    check("wd_idle", observe(), idle_obs());
    for (int k = 1; k <= TO; k++) begin
      cyc(2'b01, 2'b00, 1'b1, 32'h1234, 2'b00);
      if (k < TO) check($sformatf("wd_wait%0d", k), observe(), busy_obs(0, 1, 0, 2'b11, 0, 2'b00, 0));
      else        check("wd_fire", observe(), busy_obs(0, 0, 0, 2'b10, 0, 2'b10, 1));
    end
    cyc(2'b00, 2'b00, 1'b1, 32'h1234, 2'b00);
    check("wd_after", observe(), idle_obs());

    // Slave completes on the would-be expiry cycle: OKAY path wins.
    cyc(2'b01, 2'b00, 1'b1, 32'h0, 2'b00);
    for (int k = 1; k <= TO; k++) begin
      if (k < TO) cyc(2'b01, 2'b00, 1'b1, 32'h0, 2'b00);
      else        cyc(2'b01, 2'b00, 1'b0, 32'hCAFE, 2'b00);
    end
    check("wd_slave_wins", observe(), busy_obs(0, 1, 0, 2'b10, 32'hCAFE, 2'b00, 0));
    cyc(2'b00, 2'b00, 1'b0, 32'h0, 2'b00);

    // Reset in the 2nd BUSY cycle of an m1 transfer; pointer must return to m0.
    cyc(2'b11, 2'b00, 1'b1, 32'h0, 2'b00);
    check("rst_pre_idle", observe(), idle_obs());
    cyc(2'b11, 2'b00, 1'b1, 32'h0, 2'b00);
    check("rst_pre_busy", observe(), busy_obs(1, 1, 0, 2'b11, 0, 2'b00, 0));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_mid", observe(), idle_obs());
    cyc(2'b11, 2'b00, 1'b1, 32'h0, 2'b00);
    check("rst_first_grant", observe(), busy_obs(0, 1, 0, 2'b11, 0, 2'b00, 0));

    // Granted m0 drops its read while m1 waits.
    cyc(2'b10, 2'b00, 1'b1, 32'h0, 2'b00);
    check("abort", observe(), busy_obs(0, 0, 0, 2'b11, 0, 2'b00, 0));
    cyc(2'b10, 2'b00, 1'b1, 32'h0, 2'b00);
    check("abort_idle", observe(), idle_obs());
    cyc(2'b10, 2'b00, 1'b1, 32'h0, 2'b00);
    check("abort_regrant", observe(), busy_obs(1, 1, 0, 2'b11, 0, 2'b00, 0));

    // Randomized run against the reference model.
    do_reset();
    m_busy = 0; m_ptr = 0; m_owner = 0; m_elapsed = 0;
    for (int c = 0; c < 3000; c++) begin
      logic [N-1:0] rd, wr, req, mw;
      logic sw, r, w, act, fire, dn;
      rd = m_read; wr = m_write;
      if ($urandom_range(0, 15) == 0) rd = N'($urandom);
      if ($urandom_range(0, 15) == 0) wr = N'($urandom) & N'($urandom);
      if (((c / 200) % 2) == 1) sw = ($urandom_range(0, 15) != 0);
      else                      sw = ($urandom_range(0, 1) != 0);
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        maddr[i] = AW'($urandom); mwdata[i] = $urandom; mbe[i] = BW'($urandom);
      end
      m_read = rd; m_write = wr; s_waitrequest = sw;
      s_readdata = $urandom; s_response = ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b00;
      #1;
      req = rd | wr;
      e = idle_obs();
      if (m_busy != 0) begin
        r = rd[m_owner]; w = wr[m_owner]; act = r | w;
        fire = act && sw && (m_elapsed == TO - 1);
        dn   = act && !sw;
        mw = '1;
        mw[m_owner] = sw && !fire;
        e = busy_obs(m_owner, r && !fire, w && !r && !fire, mw,
                     dn ? s_readdata : '0, dn ? s_response : (fire ? 2'b10 : 2'b00), fire);
        check($sformatf("rand%0d", c), observe(), e);
        if (!act || dn || fire) begin
          m_busy = 0;
          m_ptr  = (m_owner + 1) % N;
        end else begin
          m_elapsed++;
        end
      end else begin
        check($sformatf("rand%0d", c), observe(), e);
        if (req != 0) begin
          for (int k = N - 1; k >= 0; k--) begin
            if (req[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
          end
          m_busy = 1;
          m_elapsed = 0;
        end
      end
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
